// File: rtl/bsg_parallel_in_serial_out_const_pkg.sv
// Shared helpers for the fixed-ratio serializer.
// Provides the safe clog2 used for index widths.
package bsg_parallel_in_serial_out_const_pkg;

  // Width of an index into n items, never below one bit.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_mux.sv
// Lane selector: picks one width_p slice out of els_p packed lanes.
// A single lane passes straight through and ignores the select.
module bsg_mux
  import bsg_parallel_in_serial_out_const_pkg::*;
#(
  parameter int width_p   = 1,
  parameter int els_p     = 2,
  parameter int lg_els_lp = safe_clog2(els_p)
) (
  input  logic [els_p-1:0][width_p-1:0] data_i,
  input  logic [lg_els_lp-1:0]          sel_i,
  output logic [width_p-1:0]            data_o
);

  if (els_p == 1) begin : g_one
    logic unused_sel;
    assign unused_sel = ^sel_i;
    assign data_o = data_i[0];
  end else begin : g_many
    assign data_o = data_i[sel_i];
  end

endmodule

// File: rtl/bsg_parallel_in_serial_out_const.sv
// Fixed-ratio serializer: one els_p*width_p word out as els_p beats.
// Define BSG_PARALLEL_IN_SERIAL_OUT_CONST_LAST_EN to expose last_o.
module bsg_parallel_in_serial_out_const
  import bsg_parallel_in_serial_out_const_pkg::*;
#(
  parameter int width_p                 = 8,
  parameter int els_p                   = 4,
  parameter int hi_to_lo_p              = 0,
  parameter int use_minimal_buffering_p = 0
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  output logic                           ready_and_o,
  input  logic [els_p-1:0][width_p-1:0]  data_i,
  output logic                           v_o,
  output logic [width_p-1:0]             data_o,
`ifdef BSG_PARALLEL_IN_SERIAL_OUT_CONST_LAST_EN
  output logic                           last_o,
`endif
  input  logic                           ready_and_i
);

  localparam int lg_els_lp = safe_clog2(els_p);
  localparam logic [lg_els_lp-1:0] last_idx_lp =
    lg_els_lp'(els_p - 1);

  logic [els_p-1:0][width_p-1:0] buf_r;
  logic                          full_r;
  logic [lg_els_lp-1:0]          cnt_r;
  logic [lg_els_lp-1:0]          sel;
  logic                          last;
  logic                          beat_done;
  logic                          load;

  assign last      = (cnt_r == last_idx_lp);
  assign beat_done = full_r & ready_and_i;

  // Fast mode reloads on the last beat so words stream with no gap.
  if (use_minimal_buffering_p != 0) begin : g_min
    assign ready_and_o = ~full_r;
  end else begin : g_fast
    assign ready_and_o = ~full_r | (ready_and_i & last);
  end

  assign load = v_i & ready_and_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full_r <= 1'b0;
      cnt_r  <= '0;
    end else begin
      if (load)
        full_r <= 1'b1;
      else if (beat_done & last)
        full_r <= 1'b0;
      if (beat_done)
        cnt_r <= last ? '0 : cnt_r + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load)
      buf_r <= data_i;
  end

  if (hi_to_lo_p != 0) begin : g_rev
    assign sel = last_idx_lp - cnt_r;
  end else begin : g_fwd
    assign sel = cnt_r;
  end

  bsg_mux #(
    .width_p (width_p),
    .els_p   (els_p)
  ) u_mux (
    .data_i (buf_r),
    .sel_i  (sel),
    .data_o (data_o)
  );

  assign v_o = full_r;

`ifdef BSG_PARALLEL_IN_SERIAL_OUT_CONST_LAST_EN
  assign last_o = full_r & last;
`endif

`ifndef SYNTHESIS
  a_els : assert property (@(posedge clk_i) els_p >= 1);
  a_nox : assert property (@(posedge clk_i) disable iff (reset_i)
    !$isunknown({v_i, ready_and_i}));
`endif

endmodule

// File: tb/tb_bsg_parallel_in_serial_out_const.sv
// Bench for the fixed-ratio serializer across four configurations.
// Scoreboard monitor checks beat order; tasks check cycle timing.
module tb_bsg_parallel_in_serial_out_const;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  v_i = '0;
  logic [3:0]  ri  = '0;
  logic [31:0] di [4];
  wire  [3:0]  ro;
  wire  [3:0]  vo;
  wire  [7:0]  d0, d1, d2;
  wire  [15:0] d3;
`ifdef BSG_PARALLEL_IN_SERIAL_OUT_CONST_LAST_EN
  wire  [3:0]  lo;
`endif

  int total = 0;
  int bad   = 0;
  int act   = 0;
  logic [15:0] q [$];

  // 0: fwd fast, 1: reversed fast, 2: fwd minimal, 3: one lane x16
  bsg_parallel_in_serial_out_const #(
    .width_p(8), .els_p(4), .hi_to_lo_p(0),
    .use_minimal_buffering_p(0)
  ) u_fwd (
    .clk_i(clk), .reset_i(rst), .v_i(v_i[0]),
    .ready_and_o(ro[0]), .data_i(di[0]), .v_o(vo[0]),
    .data_o(d0),
`ifdef BSG_PARALLEL_IN_SERIAL_OUT_CONST_LAST_EN
    .last_o(lo[0]),
`endif
    .ready_and_i(ri[0])
  );

  bsg_parallel_in_serial_out_const #(
    .width_p(8), .els_p(4), .hi_to_lo_p(1),
    .use_minimal_buffering_p(0)
  ) u_rev (
    .clk_i(clk), .reset_i(rst), .v_i(v_i[1]),
    .ready_and_o(ro[1]), .data_i(di[1]), .v_o(vo[1]),
    .data_o(d1),
`ifdef BSG_PARALLEL_IN_SERIAL_OUT_CONST_LAST_EN
    .last_o(lo[1]),
`endif
    .ready_and_i(ri[1])
  );

  bsg_parallel_in_serial_out_const #(
    .width_p(8), .els_p(4), .hi_to_lo_p(0),
    .use_minimal_buffering_p(1)
  ) u_min (
    .clk_i(clk), .reset_i(rst), .v_i(v_i[2]),
    .ready_and_o(ro[2]), .data_i(di[2]), .v_o(vo[2]),
    .data_o(d2),
`ifdef BSG_PARALLEL_IN_SERIAL_OUT_CONST_LAST_EN
    .last_o(lo[2]),
`endif
    .ready_and_i(ri[2])
  );

  bsg_parallel_in_serial_out_const #(
    .width_p(16), .els_p(1), .hi_to_lo_p(0),
    .use_minimal_buffering_p(0)
  ) u_one (
    .clk_i(clk), .reset_i(rst), .v_i(v_i[3]),
    .ready_and_o(ro[3]), .data_i(di[3][15:0]), .v_o(vo[3]),
    .data_o(d3),
`ifdef BSG_PARALLEL_IN_SERIAL_OUT_CONST_LAST_EN
    .last_o(lo[3]),
`endif
    .ready_and_i(ri[3])
  );

  function automatic logic [15:0] dout(input int k);
    case (k)
      0:       return {8'h0, d0};
      1:       return {8'h0, d1};
      2:       return {8'h0, d2};
      default: return d3;
    endcase
  endfunction

  // Scoreboard: lanes queued in expected order on accept,
  // popped on every completed beat of the active instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (vo[act] && ri[act]) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sb_empty k=%0d got %0h want none",
                   act, dout(act));
        end else begin
          logic [15:0] e;
          e = q.pop_front();
          if (dout(act) !== e) begin
            bad++;
            $display("FAIL sb_beat k=%0d got %0h want %0h",
                     act, dout(act), e);
          end
        end
      end
      if (v_i[act] && ro[act]) begin
        int n;
        int w;
        n = (act == 3) ? 1 : 4;
        w = (act == 3) ? 16 : 8;
        for (int i = 0; i < n; i++) begin
          int l;
          logic [31:0] s;
          l = (act == 1) ? (n - 1 - i) : i;
          s = di[act] >> (l * w);
          q.push_back((w == 16) ? s[15:0] : {8'h0, s[7:0]});
        end
      end
    end
  end

  task automatic at_drive();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (vo !== 4'h0) begin
      bad++;
      $display("FAIL reset_vo got %b want 0000", vo);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    total++;
    if (ro !== 4'hF || vo !== 4'h0) begin
      bad++;
      $display("FAIL reset_rdy got ro=%b vo=%b want 1111/0000",
               ro, vo);
    end
  endtask

  task automatic test_order(input int k, input logic [31:0] w,
                            input logic [31:0] ex);
    act = k;
    at_drive();
    ri[k] = 1'b1; v_i[k] = 1'b1; di[k] = w;
    @(negedge clk);
    total++;
    if (ro[k] !== 1'b1) begin
      bad++;
      $display("FAIL order_rdy k=%0d got %b want 1", k, ro[k]);
    end
    at_drive();
    v_i[k] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] e;
      @(negedge clk);
      e = {8'h0, ex[i*8 +: 8]};
      total++;
      if (vo[k] !== 1'b1 || dout(k) !== e) begin
        bad++;
        $display("FAIL order_beat k=%0d i=%0d got v=%b d=%0h want 1/%0h",
                 k, i, vo[k], dout(k), e);
      end
`ifdef BSG_PARALLEL_IN_SERIAL_OUT_CONST_LAST_EN
      total++;
      if (lo[k] !== (i == 3)) begin
        bad++;
        $display("FAIL order_last k=%0d i=%0d got %b want %b",
                 k, i, lo[k], (i == 3));
      end
`endif
    end
    @(negedge clk);
    total++;
    if (vo[k] !== 1'b0) begin
      bad++;
      $display("FAIL order_idle k=%0d got %b want 0", k, vo[k]);
    end
    at_drive();
    ri[k] = 1'b0;
  endtask

  task automatic test_back_to_back(input int k,
                                   input logic [9:0] ev,
                                   input logic [9:0] er);
    logic [9:0] vs;
    logic [9:0] rs;
    int sent;
    vs = '0; rs = '0; sent = 0;
    act = k;
    at_drive();
    ri[k] = 1'b1; v_i[k] = 1'b1; di[k] = 32'h44332211;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c > 0) begin
        vs[c-1] = vo[k];
        rs[c-1] = ro[k];
      end
      if (v_i[k] && ro[k]) sent++;
      at_drive();
      v_i[k] = (sent < 2);
      di[k]  = (sent == 1) ? 32'h88776655 : 32'h44332211;
    end
    ri[k] = 1'b0;
    total++;
    if (vs !== ev || sent != 2) begin
      bad++;
      $display("FAIL b2b_valid k=%0d got %b/%0d want %b/2",
               k, vs, sent, ev);
    end
    total++;
    if (rs !== er) begin
      bad++;
      $display("FAIL b2b_ready k=%0d got %b want %b", k, rs, er);
    end
  endtask

  task automatic test_backpressure();
    act = 0;
    at_drive();
    ri[0] = 1'b1; v_i[0] = 1'b1; di[0] = 32'h44332211;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        logic [7:0] e;
        e = (c == 1) ? 8'h11 : (c == 2) ? 8'h22 :
            (c <= 6) ? 8'h33 : 8'h44;
        total++;
        if (vo[0] !== (c < 8) ||
            (c < 8 && dout(0) !== {8'h0, e})) begin
          bad++;
          $display("FAIL bp_beat c=%0d got v=%b d=%0h want %b/%0h",
                   c, vo[0], dout(0), (c < 8), e);
        end
      end
      if (c >= 1 && c <= 5) begin
        total++;
        if (ro[0] !== 1'b0) begin
          bad++;
          $display("FAIL bp_rdy c=%0d got %b want 0", c, ro[0]);
        end
      end
      at_drive();
      ri[0]  = !(c >= 2 && c <= 4);
      v_i[0] = (c < 5);
      if (c == 0) di[0] = 32'hEEEEEEEE;
    end
    ri[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    act = 0;
    at_drive();
    ri[0] = 1'b1; v_i[0] = 1'b1; di[0] = 32'h44332211;
    @(negedge clk);
    at_drive();
    v_i[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (vo[0] !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_vo got %b want 0", vo[0]);
    end
    q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    total++;
    if (ro[0] !== 1'b1 || vo[0] !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_rdy got ro=%b vo=%b want 1/0",
               ro[0], vo[0]);
    end
    at_drive();
    v_i[0] = 1'b1; di[0] = 32'hDDCCBBAA;
    @(negedge clk);
    at_drive();
    v_i[0] = 1'b0;
    @(negedge clk);
    total++;
    if (vo[0] !== 1'b1 || dout(0) !== 16'h00AA) begin
      bad++;
      $display("FAIL rst_mid_first got v=%b d=%0h want 1/aa",
               vo[0], dout(0));
    end
    repeat (4) @(negedge clk);
    at_drive();
    ri[0] = 1'b0;
  endtask

  task automatic test_one_lane();
    act = 3;
    at_drive();
    ri[3] = 1'b1; v_i[3] = 1'b1; di[3] = 32'd1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      total++;
      if (c >= 1 && c <= 3) begin
        if (vo[3] !== 1'b1 || dout(3) !== 16'(c) || ro[3] !== 1'b1) begin
          bad++;
          $display("FAIL one_beat c=%0d got v=%b d=%0h r=%b want 1/%0h/1",
                   c, vo[3], dout(3), ro[3], c);
        end
      end else if (vo[3] !== 1'b0 || ro[3] !== 1'b1) begin
        bad++;
        $display("FAIL one_idle c=%0d got v=%b r=%b want 0/1",
                 c, vo[3], ro[3]);
      end
`ifdef BSG_PARALLEL_IN_SERIAL_OUT_CONST_LAST_EN
      total++;
      if (lo[3] !== vo[3]) begin
        bad++;
        $display("FAIL one_last c=%0d got %b want %b",
                 c, lo[3], vo[3]);
      end
`endif
      at_drive();
      di[3]  = 32'(c + 2);
      v_i[3] = (c < 2);
    end
    ri[3] = 1'b0;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL sb_left got %0d want 0", q.size());
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) di[k] = '0;
    test_reset();
    test_order(0, 32'h44332211, 32'h44332211);
    test_order(1, 32'h44332211, 32'h11223344);
    test_back_to_back(0, 10'b0011111111, 10'b1110001000);
    test_back_to_back(2, 10'b0111101111, 10'b1000010000);
    test_backpressure();
    test_reset_mid();
    test_one_lane();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
